// File: rtl/tone_sequencer.sv
// Simon Says pattern playback: walks the pattern memory, plays each colour's
// tone for TONE_CYC cycles with its lamp lit, then stays silent for GAP_CYC cycles.
module tone_sequencer #(
    parameter int MAX_LEN  = 32,
    parameter int TONE_CYC = 25000000,
    parameter int GAP_CYC  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] length,
    input  logic [1:0] step_color,
    output logic [4:0] step_idx,
    output logic [3:0] sound_select,
    output logic       play,
    output logic [3:0] light,
    output logic       busy,
    output logic       done
);

    localparam int CMAX = (TONE_CYC > GAP_CYC) ? TONE_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TONE_LAST = CW'(TONE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [5:0]    LEN_MAX   = 6'(MAX_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_TONE  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [5:0]    r_len_q;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_step_idx;
    logic [3:0]    r_sound_select;
    logic          r_play;
    logic [3:0]    r_light;
    logic          r_busy;
    logic          r_done;

    logic [5:0]    w_len_clip;
    logic          w_last_step;
    logic [CW-1:0] w_cnt_inc;

    assign w_len_clip  = (length > LEN_MAX) ? LEN_MAX : length;
    assign w_last_step = ({1'b0, r_step_idx} == (r_len_q - 6'd1));
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_len_q        <= '0;
            r_cnt          <= '0;
            r_step_idx     <= '0;
            r_sound_select <= '0;
            r_play         <= 1'b0;
            r_light        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                // Abort drops straight back to IDLE; no done pulse follows.
                r_state <= S_IDLE;
                r_play  <= 1'b0;
                r_light <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_len_q    <= w_len_clip;
                            r_step_idx <= '0;
                            if (w_len_clip == 6'd0) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        // Colour is captured here; sound_select keeps it through the gap.
                        r_cnt          <= '0;
                        r_state        <= S_TONE;
                        r_play         <= 1'b1;
                        r_sound_select <= {2'b00, step_color};
                        r_light        <= 4'b0001 << step_color;
                    end
                    S_TONE: begin
                        if (r_cnt >= TONE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                            r_play  <= 1'b0;
                            r_light <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt >= GAP_LAST) begin
                            r_cnt <= '0;
                            if (w_last_step) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_FETCH;
                                r_step_idx <= r_step_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_play  <= 1'b0;
                        r_light <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_play  <= 1'b0;
                        r_light <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_idx     = r_step_idx;
    assign sound_select = r_sound_select;
    assign play         = r_play;
    assign light        = r_light;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
